// File: rtl/tt_pin_bist.sv
// Built-in self-test harness: resets a DUT, drives LFSR stimulus, compresses
// latency-aligned responses into a MISR and compares against a golden signature.
module tt_pin_bist #(
    parameter int unsigned     IN_W       = 8,
    parameter int unsigned     OUT_W      = 8,
    parameter int unsigned     SIG_W      = 16,
    parameter int unsigned     CYC_W      = 16,
    parameter int unsigned     LAT        = 0,
    parameter int unsigned     RST_CYCLES = 2,
    parameter logic [IN_W-1:0] LFSR_POLY  = 8'h1D,
    parameter logic [IN_W-1:0] LFSR_SEED  = 8'h01,
    parameter logic [SIG_W-1:0] MISR_POLY = 16'h1021,
    parameter logic [SIG_W-1:0] MISR_SEED = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CYC_W-1:0]  cycles,
    input  logic [SIG_W-1:0]  expected_sig,
    output logic [IN_W-1:0]   stim,
    input  logic [OUT_W-1:0]  resp,
    output logic              dut_rst,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature
);

    // Headroom so cycles + LAT never wraps the elapsed counter.
    localparam int unsigned CNT_W = CYC_W + 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cyc_q;
    logic [CNT_W-1:0]   rcnt_q;
    logic [CNT_W-1:0]   iss_q;
    logic [CNT_W-1:0]   el_q;
    logic [CNT_W-1:0]   cap_q;
    logic [SIG_W-1:0]   exp_q;
    logic [SIG_W-1:0]   misr_q;
    logic [IN_W-1:0]    stim_q;
    logic               dut_rst_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;

    logic [IN_W-1:0]    lfsr_d;
    logic [SIG_W-1:0]   misr_d;
    logic [CNT_W-1:0]   cap_d;
    logic               capture;
    logic               last_issue;
    logic               cap_done;

    // Next LFSR/MISR values and capture bookkeeping for the current cycle.
    always_comb begin
        lfsr_d     = {stim_q[IN_W-2:0], 1'b0} ^ (stim_q[IN_W-1] ? LFSR_POLY : '0);
        misr_d     = misr_q;
        cap_d      = cap_q;
        capture    = ((state_q == S_RUN) || (state_q == S_FLUSH))
                     && ((el_q + CNT_W'(1)) > CNT_W'(LAT))
                     && (cap_q < cyc_q);
        if (capture) begin
            misr_d = {misr_q[SIG_W-2:0], 1'b0}
                     ^ (misr_q[SIG_W-1] ? MISR_POLY : '0)
                     ^ SIG_W'(resp);
            cap_d  = cap_q + CNT_W'(1);
        end
        last_issue = (iss_q + CNT_W'(1)) == cyc_q;
        cap_done   = cap_d == cyc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            rcnt_q    <= '0;
            iss_q     <= '0;
            el_q      <= '0;
            cap_q     <= '0;
            exp_q     <= '0;
            misr_q    <= MISR_SEED;
            stim_q    <= '0;
            dut_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cyc_q     <= CNT_W'(cycles);
                        exp_q     <= expected_sig;
                        misr_q    <= MISR_SEED;
                        stim_q    <= '0;
                        pass_q    <= 1'b0;
                        rcnt_q    <= '0;
                        busy_q    <= 1'b1;
                        dut_rst_q <= 1'b1;
                        state_q   <= S_RESET;
                    end
                end
                S_RESET: begin
                    if (rcnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        dut_rst_q <= 1'b0;
                        iss_q     <= '0;
                        el_q      <= '0;
                        cap_q     <= '0;
                        if (cyc_q == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            pass_q  <= (misr_d == exp_q);
                        end else begin
                            state_q <= S_RUN;
                            stim_q  <= LFSR_SEED;
                        end
                    end else begin
                        rcnt_q <= rcnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    iss_q  <= iss_q + CNT_W'(1);
                    el_q   <= el_q + CNT_W'(1);
                    misr_q <= misr_d;
                    cap_q  <= cap_d;
                    if (!last_issue) begin
                        stim_q <= lfsr_d;
                    end else if (cap_done) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (misr_d == exp_q);
                        stim_q  <= '0;
                    end else begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    el_q   <= el_q + CNT_W'(1);
                    misr_q <= misr_d;
                    cap_q  <= cap_d;
                    if (cap_done) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (misr_d == exp_q);
                        stim_q  <= '0;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stim      = stim_q;
    assign dut_rst   = dut_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;

endmodule

// File: tb/tb_tt_pin_bist.sv
// Scoreboard bench for tt_pin_bist: default, LAT=3 and narrow-LFSR instances.
module tb_tt_pin_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] done_at;
        logic [15:0] sig;
        logic        pass;
        logic [7:0]  rcnt;
    } exp_t;

    exp_t        q[3][$];
    logic [7:0]  sq0[$];
    logic [3:0]  sq4[$];
    int          rc[3];

    logic        rst = 1'b1;
    logic        start0 = 1'b0, start3 = 1'b0, start4 = 1'b0;
    logic [15:0] cycles0 = '0, cycles3 = '0, cycles4 = '0;
    logic [15:0] exp0 = '0, exp3 = '0;
    logic [7:0]  exp4 = '0;
    logic        loop0 = 1'b0;

    logic [7:0]  stim0, resp0, stim3, resp3;
    logic [3:0]  stim4;
    logic [7:0]  resp4;
    logic        drst0, busy0, done0, pass0;
    logic        drst3, busy3, done3, pass3;
    logic        drst4, busy4, done4, pass4;
    logic [15:0] sig0, sig3;
    logic [7:0]  sig4;
    logic [7:0]  d1 = '0, d2 = '0, d3 = '0;

    assign resp0 = loop0 ? stim0 : 8'h00;
    always @(posedge clk) begin
        d1 <= stim3;
        d2 <= d1;
        d3 <= d2;
    end
    assign resp3 = d3;
    assign resp4 = {4'hA, stim4};

    tt_pin_bist u0 (
        .clk(clk), .rst(rst), .start(start0), .cycles(cycles0), .expected_sig(exp0),
        .stim(stim0), .resp(resp0), .dut_rst(drst0), .busy(busy0), .done(done0),
        .pass(pass0), .signature(sig0)
    );

    tt_pin_bist #(.LAT(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .cycles(cycles3), .expected_sig(exp3),
        .stim(stim3), .resp(resp3), .dut_rst(drst3), .busy(busy3), .done(done3),
        .pass(pass3), .signature(sig3)
    );

    tt_pin_bist #(
        .IN_W(4), .OUT_W(8), .SIG_W(8), .LFSR_POLY(4'h3), .LFSR_SEED(4'h1),
        .MISR_POLY(8'h07), .MISR_SEED(8'h00)
    ) u4 (
        .clk(clk), .rst(rst), .start(start4), .cycles(cycles4), .expected_sig(exp4),
        .stim(stim4), .resp(resp4), .dut_rst(drst4), .busy(busy4), .done(done4),
        .pass(pass4), .signature(sig4)
    );

    logic        busy_a[3], drst_a[3], done_a[3], pass_a[3];
    logic [15:0] sig_a[3];
    assign busy_a[0] = busy0;  assign busy_a[1] = busy3;  assign busy_a[2] = busy4;
    assign drst_a[0] = drst0;  assign drst_a[1] = drst3;  assign drst_a[2] = drst4;
    assign done_a[0] = done0;  assign done_a[1] = done3;  assign done_a[2] = done4;
    assign pass_a[0] = pass0;  assign pass_a[1] = pass3;  assign pass_a[2] = pass4;
    assign sig_a[0]  = sig0;   assign sig_a[1]  = sig3;   assign sig_a[2]  = {8'h00, sig4};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference models of the stimulus and signature recurrences.
    function automatic logic [7:0] lfsr8(input logic [7:0] s);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
    endfunction
    function automatic logic [3:0] lfsr4(input logic [3:0] s);
        return {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0);
    endfunction
    function automatic logic [15:0] misr16(input logic [15:0] m, input logic [15:0] r);
        return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ r;
    endfunction
    function automatic logic [7:0] misr8(input logic [7:0] m, input logic [7:0] r);
        return {m[6:0], 1'b0} ^ (m[7] ? 8'h07 : 8'h00) ^ r;
    endfunction
    function automatic logic [15:0] ref_loop(input int n);
        logic [15:0] m = 16'h0000;
        logic [7:0]  s = 8'h01;
        for (int k = 0; k < n; k++) begin
            m = misr16(m, {8'h00, s});
            s = lfsr8(s);
        end
        return m;
    endfunction
    function automatic logic [7:0] ref_u4(input int n);
        logic [7:0] m = 8'h00;
        logic [3:0] s = 4'h1;
        for (int k = 0; k < n; k++) begin
            m = misr8(m, {4'hA, s});
            s = lfsr4(s);
        end
        return m;
    endfunction

    function automatic void expect_done(input int i, input int at, input logic [15:0] sg, input logic ps);
        exp_t e;
        e.done_at = 32'(at);
        e.sig     = sg;
        e.pass    = ps;
        e.rcnt    = 8'd2;
        q[i].push_back(e);
    endfunction

    // Scoreboard monitor: pops an expectation on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        logic [7:0] s8;
        logic [3:0] s4;
        for (int i = 0; i < 3; i++) begin
            if (!busy_a[i]) rc[i] = 0;
            else if (drst_a[i]) rc[i] = rc[i] + 1;
            if (done_a[i]) begin
                if (q[i].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL u%0d_spurious_done: done high at cycle %0d, none expected", i, cyc);
                end else begin
                    e = q[i].pop_front();
                    chk($sformatf("u%0d_done_time", i), 32'(cyc), e.done_at);
                    chk($sformatf("u%0d_signature", i), {16'h0, sig_a[i]}, {16'h0, e.sig});
                    chk($sformatf("u%0d_pass", i), {31'h0, pass_a[i]}, {31'h0, e.pass});
                    chk($sformatf("u%0d_dut_rst_cycles", i), 32'(rc[i]), {24'h0, e.rcnt});
                end
            end
        end
        if (busy0 && !drst0 && !done0 && sq0.size() > 0) begin
            s8 = sq0.pop_front();
            chk("u0_stim", {24'h0, stim0}, {24'h0, s8});
        end
        if (busy4 && !drst4 && !done4 && sq4.size() > 0) begin
            s4 = sq4.pop_front();
            chk("u4_stim", {28'h0, stim4}, {28'h0, s4});
        end
    end

    task automatic start_run(input int i, input int n, input logic [15:0] e, output int s);
        @(negedge clk);
        s = cyc;
        case (i)
            0:       begin start0 = 1'b1; cycles0 = 16'(n); exp0 = e; end
            1:       begin start3 = 1'b1; cycles3 = 16'(n); exp3 = e; end
            default: begin start4 = 1'b1; cycles4 = 16'(n); exp4 = e[7:0]; end
        endcase
        @(negedge clk);
        start0 = 1'b0;
        start3 = 1'b0;
        start4 = 1'b0;
        chk($sformatf("u%0d_busy_after_start", i), {31'h0, busy_a[i]}, 32'h1);
        chk($sformatf("u%0d_dut_rst_after_start", i), {31'h0, drst_a[i]}, 32'h1);
    endtask

    task automatic wait_idle(input int i, input int budget);
        int k = 0;
        while (busy_a[i] && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy_a[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL u%0d_timeout: busy still high after %0d cycles", i, budget);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  tbl8 [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
        logic [3:0]  tbl4 [15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};
        logic [15:0] r20, r50, r100;
        int s;
        r20  = ref_loop(20);
        r50  = ref_loop(50);
        r100 = ref_loop(100);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_stim", {24'h0, stim0}, 32'h0);
        chk("reset_dut_rst", {31'h0, drst0}, 32'h0);
        chk("reset_busy", {31'h0, busy0}, 32'h0);
        chk("reset_done", {31'h0, done0}, 32'h0);
        chk("reset_pass", {31'h0, pass0}, 32'h0);
        chk("reset_signature", {16'h0, sig0}, 32'h0);

        // Stimulus sequence with resp tied low.
        foreach (tbl8[k]) sq0.push_back(tbl8[k]);
        start_run(0, 10, 16'h0000, s);
        expect_done(0, s + 13, 16'h0000, 1'b1);
        wait_idle(0, 40);

        // Loopback signature, matching and off-by-one golden values.
        loop0 = 1'b1;
        start_run(0, 100, r100, s);
        expect_done(0, s + 103, r100, 1'b1);
        wait_idle(0, 200);
        start_run(0, 100, r100 ^ 16'h0001, s);
        expect_done(0, s + 103, r100, 1'b0);
        wait_idle(0, 200);
        start_run(0, 50, r50, s);
        expect_done(0, s + 53, r50, 1'b1);
        wait_idle(0, 100);

        // Latency-aligned instance must reproduce the LAT=0 signature.
        start_run(1, 50, r50, s);
        expect_done(1, s + 56, r50, 1'b1);
        wait_idle(1, 100);

        // Zero-length runs.
        start_run(0, 0, 16'h0000, s);
        expect_done(0, s + 3, 16'h0000, 1'b1);
        wait_idle(0, 20);
        start_run(0, 0, 16'h1234, s);
        expect_done(0, s + 3, 16'h0000, 1'b0);
        wait_idle(0, 20);

        // start and input changes mid-run are ignored.
        start_run(0, 20, r20, s);
        expect_done(0, s + 23, r20, 1'b1);
        repeat (6) @(negedge clk);
        start0 = 1'b1; cycles0 = 16'd5; exp0 = 16'hBEEF;
        @(negedge clk);
        start0 = 1'b0;
        wait_idle(0, 60);

        // Reset mid-run abandons the run without a done pulse.
        start_run(0, 20, r20, s);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'h0, busy0}, 32'h0);
        chk("abort_stim", {24'h0, stim0}, 32'h0);
        chk("abort_dut_rst", {31'h0, drst0}, 32'h0);
        chk("abort_pass", {31'h0, pass0}, 32'h0);
        chk("abort_signature", {16'h0, sig0}, 32'h0);
        repeat (30) @(negedge clk);
        start_run(0, 20, r20, s);
        expect_done(0, s + 23, r20, 1'b1);
        wait_idle(0, 60);

        // Narrow instance: period-15 stimulus, wide response bits folded in.
        for (int rep = 0; rep < 2; rep++)
            foreach (tbl4[k]) sq4.push_back(tbl4[k]);
        start_run(2, 30, {8'h00, ref_u4(30)}, s);
        expect_done(2, s + 33, {8'h00, ref_u4(30)}, 1'b1);
        wait_idle(2, 80);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("u%0d_pending_done", i), 32'(q[i].size()), 32'h0);
        chk("u0_pending_stim", 32'(sq0.size()), 32'h0);
        chk("u4_pending_stim", 32'(sq4.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
